// File: rtl/axi3_read_slave.sv
`default_nettype none
// axi3_read_slave: AXI3 read responder for FIXED/INCR/WRAP bursts from an internal preloadable memory.
// Optional request checking (SLVERR) is enabled by defining AXI_RD_ERR_CHECK_EN.
module axi3_read_slave #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ID_W-1:0]              ARID,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [3:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_W-1:0]              RID,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int                AW          = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_MEM_BYTES = ADDR_W'(MEM_DEPTH) << 2;
    localparam logic [1:0]        C_FIXED     = 2'd0;
    localparam logic [1:0]        C_INCR      = 2'd1;
    localparam logic [1:0]        C_WRAP      = 2'd2;
    localparam logic [1:0]        C_OKAY      = 2'd0;
    localparam logic [1:0]        C_SLVERR    = 2'd2;
    localparam logic [1:0]        C_DECERR    = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [1:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_last;
    logic [1:0]          w_ar_size;
    logic [1:0]          w_ar_burst;
    logic                w_ar_err;
    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W-1:0]   w_span;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [ADDR_W-1:0]   w_load_addr;
    logic                w_load_err;
    logic                w_oob;
    logic [AW-1:0]       w_idx;
    logic [DATA_W-1:0]   w_word_data;
    logic [DATA_W-1:0]   w_beat_data;
    logic [1:0]          w_beat_resp;

    // Sizes above 4 bytes advance as 4-byte beats; reserved burst type advances as INCR.
    assign w_ar_size  = (ARSIZE > 3'd2) ? 2'd2 : ARSIZE[1:0];
    assign w_ar_burst = (ARBURST == 2'd3) ? C_INCR : ARBURST;

`ifdef AXI_RD_ERR_CHECK_EN
    logic [ADDR_W-1:0] w_ar_mask;
    logic              w_len_ok;
    always_comb begin
        w_ar_mask = (C_ONE << ARSIZE) - C_ONE;
        w_len_ok  = (ARLEN == 4'd1) || (ARLEN == 4'd3) || (ARLEN == 4'd7) || (ARLEN == 4'd15);
        w_ar_err  = (ARBURST == 2'd3) || (ARSIZE > 3'd2) ||
                    ((ARBURST == C_WRAP) && (!w_len_ok || ((ARADDR & w_ar_mask) != '0)));
    end
`else
    assign w_ar_err = 1'b0;
`endif

    always_comb begin
        w_step = C_ONE << r_size;
        w_span = ADDR_W'({1'b0, r_len} + 5'd1) << r_size;
        case (r_burst)
            C_FIXED: w_next_addr = r_addr;
            C_WRAP:  w_next_addr = (r_addr & ~(w_span - C_ONE)) |
                                   ((r_addr + w_step) & (w_span - C_ONE));
            default: w_next_addr = (r_addr & ~(w_step - C_ONE)) + w_step;
        endcase
    end

    // Beat data is registered when a beat is set up, so it stays stable across stalls;
    // a preload to the word being fetched is forwarded into that fetch.
    always_comb begin
        w_load_addr = (r_state == S_IDLE) ? ARADDR : w_next_addr;
        w_load_err  = (r_state == S_IDLE) ? w_ar_err : r_err;
        w_oob       = (w_load_addr >= C_MEM_BYTES);
        w_idx       = w_load_addr[AW+1:2];
        w_word_data = (mem_we && (mem_waddr == w_idx)) ? mem_wdata : r_mem[w_idx];
        w_beat_data = (w_load_err || w_oob) ? '0 : w_word_data;
        w_beat_resp = w_load_err ? C_SLVERR : (w_oob ? C_DECERR : C_OKAY);
    end

    always_comb begin
        w_state_next = r_state;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ARREADY = reset;
                if (ARVALID && reset) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                RVALID = 1'b1;
                w_last = (r_cnt == r_len);
                if (RREADY && w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_ar_hs = ARVALID && ARREADY;
    assign w_r_hs  = RVALID && RREADY;
    assign RLAST   = w_last;
    assign RID     = r_id;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_rresp <= '0;
        end else if (w_ar_hs) begin
            r_id    <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_cnt   <= '0;
            r_size  <= w_ar_size;
            r_burst <= w_ar_burst;
            r_err   <= w_ar_err;
            r_rdata <= w_beat_data;
            r_rresp <= w_beat_resp;
        end else if (w_r_hs && !w_last) begin
            r_cnt   <= r_cnt + 4'd1;
            r_addr  <= w_next_addr;
            r_rdata <= w_beat_data;
            r_rresp <= w_beat_resp;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi3_read_slave.sv
`default_nettype none
// tb_axi3_read_slave: directed self-checking bench for the AXI3 read responder.
module tb_axi3_read_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rvalid && rready) hs_cnt <= hs_cnt + 1;
    end

    axi3_read_slave #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024)
    ) dut (
        .clock(clk), .reset(rst_n),
        .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize),
        .ARBURST(arburst), .ARVALID(arvalid), .ARREADY(arready),
        .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast),
        .RVALID(rvalid), .RREADY(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // Packed view of one R beat: {RVALID, RLAST, RID, RRESP, RDATA}.
    function automatic logic [39:0] beat();
        return {rvalid, rlast, rid, rresp, rdata};
    endfunction

    function automatic logic [40:0] all_out();
        return {arready, rvalid, rlast, rid, rresp, rdata};
    endfunction

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        @(posedge clk); #1;
        mem_we = 1'b0;
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (all_out() !== 41'd0) $display("FAIL reset_outputs: got %h expected %h", all_out(), 41'd0);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({arready, rvalid} !== 2'b10) $display("FAIL reset_release: got %b expected 10", {arready, rvalid});
        else pass_cnt++;
    endtask

    task automatic test_incr();
        logic [39:0] exp;
        rready = 1'b1;
        issue_ar(4'd5, 32'h0, 4'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, (i == 3), 4'd5, 2'd0, 32'(32'hA0 + i)};
            total_cnt++;
            if (beat() !== exp) $display("FAIL incr_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if ({arready, rvalid} !== 2'b10) $display("FAIL incr_done: got %b expected 10", {arready, rvalid});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [39:0] exp;
        logic [31:0] wdata [4];
        wdata[0] = 32'hA2; wdata[1] = 32'hA3; wdata[2] = 32'hA0; wdata[3] = 32'hA1;
        issue_ar(4'd3, 32'h8, 4'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, (i == 3), 4'd3, 2'd0, wdata[i]};
            total_cnt++;
            if (beat() !== exp) $display("FAIL wrap_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fixed_preload();
        logic [39:0] exp;
        issue_ar(4'd7, 32'h10, 4'd2, 3'd2, 2'd0);
        exp = {1'b1, 1'b0, 4'd7, 2'd0, 32'hB4};
        total_cnt++;
        if (beat() !== exp) $display("FAIL fixed_beat0: got %h expected %h", beat(), exp);
        else pass_cnt++;
        mem_we = 1'b1; mem_waddr = 10'd4; mem_wdata = 32'hC4;
        @(posedge clk); #1;
        mem_we = 1'b0;
        for (int i = 1; i < 3; i++) begin
            exp = {1'b1, (i == 2), 4'd7, 2'd0, 32'hC4};
            total_cnt++;
            if (beat() !== exp) $display("FAIL fixed_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_narrow();
        logic [39:0] exp;
        issue_ar(4'd2, 32'h3, 4'd1, 3'd0, 2'd1);
        for (int i = 0; i < 2; i++) begin
            exp = {1'b1, (i == 1), 4'd2, 2'd0, 32'(32'hA0 + i)};
            total_cnt++;
            if (beat() !== exp) $display("FAIL narrow_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int base;
        logic [39:0] exp;
        rready = 1'b0;
        base = hs_cnt;
        issue_ar(4'd9, 32'h4, 4'd1, 3'd2, 2'd1);
        exp = {1'b1, 1'b0, 4'd9, 2'd0, 32'hA1};
        total_cnt++;
        if (beat() !== exp) $display("FAIL stall_beat0: got %h expected %h", beat(), exp);
        else pass_cnt++;
        arid = 4'hE; araddr = 32'h10; arvalid = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (beat() !== exp) $display("FAIL stall_hold0: got %h expected %h", beat(), exp);
        else pass_cnt++;
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        exp = {1'b1, 1'b1, 4'd9, 2'd0, 32'hA2};
        total_cnt++;
        if (beat() !== exp) $display("FAIL stall_beat1: got %h expected %h", beat(), exp);
        else pass_cnt++;
        rready = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (beat() !== exp) $display("FAIL stall_hold1: got %h expected %h", beat(), exp);
        else pass_cnt++;
        rready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({arready, rvalid, 32'(hs_cnt - base)} !== {2'b10, 32'd2})
            $display("FAIL stall_handshakes: got rdy/vld=%b hs=%0d expected rdy/vld=10 hs=2",
                     {arready, rvalid}, hs_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_decerr();
        logic [39:0] exp;
        issue_ar(4'd4, 32'h1000, 4'd1, 3'd2, 2'd1);
        for (int i = 0; i < 2; i++) begin
            exp = {1'b1, (i == 1), 4'd4, 2'd3, 32'h0};
            total_cnt++;
            if (beat() !== exp) $display("FAIL decerr_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reserved_burst();
        logic [39:0] exp;
        issue_ar(4'd6, 32'h0, 4'd1, 3'd2, 2'd3);
        for (int i = 0; i < 2; i++) begin
`ifdef AXI_RD_ERR_CHECK_EN
            exp = {1'b1, (i == 1), 4'd6, 2'd2, 32'h0};
`else
            exp = {1'b1, (i == 1), 4'd6, 2'd0, 32'(32'hA0 + i)};
`endif
            total_cnt++;
            if (beat() !== exp) $display("FAIL reserved_beat%0d: got %h expected %h", i, beat(), exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        issue_ar(4'd8, 32'h0, 4'd3, 3'd2, 2'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (all_out() !== 41'd0) $display("FAIL midreset_outputs: got %h expected %h", all_out(), 41'd0);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({arready, rvalid, rlast} !== 3'b100)
            $display("FAIL midreset_release: got %b expected 100", {arready, rvalid, rlast});
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        for (int i = 0; i < 4; i++) preload(10'(i), 32'(32'hA0 + i));
        preload(10'd4, 32'hB4);
        test_incr();
        test_wrap();
        test_fixed_preload();
        test_narrow();
        test_stall();
        test_decerr();
        test_reserved_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
